// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: start/bin request, busy/done status and
// the packed BCD result with its overflow flag.
interface bin2bcd_seq_if #(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BITS-1:0]       bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD, one operand bit per clock; done pulses BITS cycles after accept.
// No backpressure: start is only looked at while idle, requests arriving while busy are dropped.
module bin2bcd_seq #(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] sh;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic [AW-1:0]   adj;
  logic [AW-1:0]   acc_nxt;
  logic            ovf_nxt;
  logic            accept;
  logic            last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CONV);
    accept   = (state == IDLE) && bus.start;
    last     = (state == CONV) && (cnt == LAST);
  end

  // Digits are always legal BCD here, so the adjusted value (8..12) never
  // needs a carry into the next digit; the shift alone moves it up.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
    end
    acc_nxt = {adj[AW-2:0], sh[BITS-1]};
    ovf_nxt = ovf | adj[AW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh           <= '0;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= last;
      if (accept) begin
        sh  <= bus.bin;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (state == CONV) begin
        sh  <= sh << 1;
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        ovf <= ovf_nxt;
      end
      // The published result only moves on completion, so it survives a new start.
      if (last) begin
        bus.bcd      <= acc_nxt;
        bus.overflow <= ovf_nxt;
      end
    end
  end

endmodule
